// File: rtl/infer_mul_arb_pkg.sv
// Shared definitions for the multiplier arbiter slice.
// Contents: operand/product widths, the default multiplier latency,
// the requester-tag width function, the operand payload struct and
// a small round-robin helper.
package infer_mul_arb_pkg;

    localparam int unsigned A_W             = 16;
    localparam int unsigned B_W             = 7;
    localparam int unsigned P_W             = 22;
    localparam int unsigned MUL_LATENCY_DEF = 3;

    // Operands routed from the granted requester into the multiplier.
    typedef struct packed {
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
    } mul_operands_t;

    // Tag width needed to name one of n requesters (never narrower than 1 bit).
    function automatic int unsigned tag_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Pointer value that follows requester g in round-robin order.
    function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/infer_mul_mul_16ns_7ns_22_4_1.sv
// Pipelined unsigned 16x7 multiplier, product truncated to 22 bits.
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   ce          - clock enable; every register advances only when high
//   din0, din1  - unsigned multiplicand / multiplier
//   dout        - low 22 bits of din0*din1, LATENCY enabled edges after capture
module infer_mul_mul_16ns_7ns_22_4_1
    import infer_mul_arb_pkg::*;
#(
    parameter int unsigned LATENCY = MUL_LATENCY_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ce,
    input  logic [A_W-1:0] din0,
    input  logic [B_W-1:0] din1,
    output logic [P_W-1:0] dout
);

    localparam int unsigned F_W = A_W + B_W;

    logic [A_W-1:0] a_q;
    logic [B_W-1:0] b_q;
    logic [P_W-1:0] prod_trunc;

    // Operand capture stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else if (ce) begin
            a_q <= din0;
            b_q <= din1;
        end
    end

    // Full-width product, high bits dropped on purpose.
    assign prod_trunc = P_W'(F_W'(a_q) * F_W'(b_q));

    generate
        if (LATENCY == 1) begin : g_lat1
            assign dout = prod_trunc;
        end else begin : g_pipe
            logic [P_W-1:0] p_q [LATENCY-1];

            // Product retiming stages behind the capture stage.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < LATENCY - 1; i++) begin
                        p_q[i] <= '0;
                    end
                end else if (ce) begin
                    p_q[0] <= prod_trunc;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        p_q[i] <= p_q[i-1];
                    end
                end
            end

            assign dout = p_q[LATENCY-2];
        end
    endgenerate

endmodule

// File: rtl/infer_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NUM_REQ requesters.
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   req_valid   - per-requester operand valid
//   req_ready   - per-requester accept (one-hot or zero, combinational)
//   req_a/req_b - packed operands, requester i at [16i+15:16i] / [7i+6:7i]
//   rsp_valid   - per-requester result valid (one-hot or zero)
//   rsp_ready   - per-requester result accept
//   rsp_p       - shared product bus, zero when no result is presented
//   busy        - any operation in flight
module infer_mul_arbiter
    import infer_mul_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [P_W-1:0]         rsp_p,
    output logic                   busy
);

    localparam int unsigned TAG_W = tag_w(NUM_REQ);

    logic [TAG_W-1:0]       rr_ptr;
    logic [TAG_W-1:0]       grant;
    logic                   found;
    logic                   ce;
    logic                   accept;
    logic [MUL_LATENCY-1:0] vld_q;
    logic [TAG_W-1:0]       tag_q [MUL_LATENCY];
    logic                   out_vld;
    logic [TAG_W-1:0]       out_tag;
    mul_operands_t          ops;
    logic [P_W-1:0]         mul_dout;

    assign out_vld = vld_q[MUL_LATENCY-1];
    assign out_tag = tag_q[MUL_LATENCY-1];

    // Whole datapath freezes while the presented result is refused.
    assign ce = !(out_vld && !rsp_ready[out_tag]);

    // Round-robin pick: the lowest valid index overall is the wrap-around
    // fallback, overridden by the lowest valid index at or above rr_ptr.
    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                found = 1'b1;
                grant = TAG_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (TAG_W'(i) >= rr_ptr)) begin
                grant = TAG_W'(i);
            end
        end
    end

    assign accept = found && ce && !reset;

    // One-hot ready toward the granted requester.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (grant == TAG_W'(i));
        end
    end

    // Operand mux from the granted requester.
    always_comb begin
        ops = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == TAG_W'(i)) begin
                ops.a = req_a[i*A_W +: A_W];
                ops.b = req_b[i*B_W +: B_W];
            end
        end
    end

    // Round-robin pointer moves past the requester just served.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= TAG_W'(rr_next(32'(grant), NUM_REQ));
        end
    end

    // Valid/tag pipeline aligned with the multiplier; bubbles travel with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else if (ce) begin
            vld_q[0] <= accept;
            tag_q[0] <= grant;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    infer_mul_mul_16ns_7ns_22_4_1 #(
        .LATENCY (MUL_LATENCY)
    ) u_mul (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .din0  (ops.a),
        .din1  (ops.b),
        .dout  (mul_dout)
    );

    // Response steering; outputs read zero throughout reset.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = !reset && out_vld && (out_tag == TAG_W'(i));
        end
    end

    assign rsp_p = (!reset && out_vld) ? mul_dout : '0;
    assign busy  = !reset && (|vld_q);

    // Handshake encodings stay one-hot or zero.
    a_req_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
    a_rsp_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(rsp_valid));

endmodule

// File: tb/tb_infer_mul_arbiter.sv
// Self-checking bench for infer_mul_arbiter (NUM_REQ=2, MUL_LATENCY=3).
// The reference model keeps in-flight operations in a queue stamped with
// the count of non-stalled cycles at acceptance; an operation is presented
// once that count has advanced by MUL_LATENCY.
module tb_infer_mul_arbiter;

    localparam int N    = 2;
    localparam int L    = 3;
    localparam int PMOD = 1 << 22;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [31:0]   req_a;
    logic [13:0]   req_b;
    logic [N-1:0]  rsp_valid;
    logic [N-1:0]  rsp_ready;
    logic [21:0]   rsp_p;
    logic          busy;

    always #5 clk = ~clk;

    infer_mul_arbiter #(
        .NUM_REQ     (N),
        .MUL_LATENCY (L)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .busy      (busy)
    );

    typedef struct {
        int tag;
        int p;
        int t0;
    } op_t;

    op_t          q[$];
    int           rr;
    int           t_eff;
    bit           e_out;
    int           e_tag;
    bit           e_ce;
    bit           e_acc;
    int           e_g;
    int           e_p;
    logic [N-1:0] e_ready;
    logic [N-1:0] e_rsp_valid;
    logic [21:0]  e_rsp_p;
    logic         e_busy;
    int           vectors;
    int           miscompares;

    // Expected outputs for the current inputs and model state.
    task automatic model_eval();
        bit          found;
        int          idx;
        logic [15:0] av;
        logic [6:0]  bv;
        e_out = (q.size() > 0) && (q[0].t0 + L == t_eff);
        e_tag = e_out ? q[0].tag : 0;
        e_ce  = !(e_out && (((rsp_ready >> e_tag) & 1) == 0));
        found = 0;
        e_g   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (rr + k) % N;
            if (!found && (((req_valid >> idx) & 1) != 0)) begin
                found = 1;
                e_g   = idx;
            end
        end
        e_acc       = found && e_ce && !reset;
        av          = 16'(req_a >> (16 * e_g));
        bv          = 7'(req_b >> (7 * e_g));
        e_p         = int'((longint'(av) * longint'(bv)) % longint'(PMOD));
        e_ready     = e_acc ? (N'(1) << e_g) : '0;
        e_rsp_valid = (e_out && !reset) ? (N'(1) << e_tag) : '0;
        e_rsp_p     = (e_out && !reset) ? 22'(q[0].p) : '0;
        e_busy      = (q.size() > 0) && !reset;
    endtask

    // Advance the model across a rising edge.
    task automatic model_commit();
        op_t o;
        if (reset) begin
            q.delete();
            rr = 0;
        end else if (e_ce) begin
            if (e_out) void'(q.pop_front());
            if (e_acc) begin
                o.tag = e_g;
                o.p   = e_p;
                o.t0  = t_eff;
                q.push_back(o);
                rr = (e_g + 1) % N;
            end
            t_eff++;
        end
    endtask

    task automatic apply(input logic rst, input logic [N-1:0] v, input logic [31:0] a,
                         input logic [13:0] b, input logic [N-1:0] rdy);
        reset     = rst;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = rdy;
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 4; c++) begin
            apply(c < 3, (c < 3) ? 2'($urandom) : 2'b00, $urandom, 14'($urandom), 2'($urandom));
            vectors++; if (req_ready !== e_ready) begin miscompares++; $display("FAIL reset c%0d req_ready got %b exp %b", c, req_ready, e_ready); end
            vectors++; if (rsp_valid !== e_rsp_valid) begin miscompares++; $display("FAIL reset c%0d rsp_valid got %b exp %b", c, rsp_valid, e_rsp_valid); end
            vectors++; if (rsp_p !== e_rsp_p) begin miscompares++; $display("FAIL reset c%0d rsp_p got %0d exp %0d", c, rsp_p, e_rsp_p); end
            vectors++; if (busy !== e_busy) begin miscompares++; $display("FAIL reset c%0d busy got %b exp %b", c, busy, e_busy); end
            advance();
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] pat;
        for (int c = 0; c < 10; c++) begin
            apply(1'b0, (c < 6) ? 2'b11 : 2'b00, $urandom, 14'($urandom), 2'b11);
            vectors++; if (req_ready !== e_ready) begin miscompares++; $display("FAIL fair c%0d req_ready got %b exp %b", c, req_ready, e_ready); end
            vectors++; if (rsp_valid !== e_rsp_valid) begin miscompares++; $display("FAIL fair c%0d rsp_valid got %b exp %b", c, rsp_valid, e_rsp_valid); end
            vectors++; if (rsp_p !== e_rsp_p) begin miscompares++; $display("FAIL fair c%0d rsp_p got %0d exp %0d", c, rsp_p, e_rsp_p); end
            vectors++; if (busy !== e_busy) begin miscompares++; $display("FAIL fair c%0d busy got %b exp %b", c, busy, e_busy); end
            if (c < 6) begin
                pat = (c % 2 == 0) ? 2'b01 : 2'b10;
                vectors++; if (req_ready !== pat) begin miscompares++; $display("FAIL fair_grant c%0d got %b exp %b", c, req_ready, pat); end
            end
            if (c >= 3 && c < 9) begin
                pat = ((c - 3) % 2 == 0) ? 2'b01 : 2'b10;
                vectors++; if (rsp_valid !== pat) begin miscompares++; $display("FAIL fair_order c%0d got %b exp %b", c, rsp_valid, pat); end
            end
            advance();
        end
    endtask

    task automatic test_single_op();
        for (int c = 0; c < 6; c++) begin
            apply(1'b0, (c == 0) ? 2'b01 : 2'b00, {16'd0, 16'd1000}, {7'd0, 7'd100}, 2'b11);
            vectors++; if (req_ready !== e_ready) begin miscompares++; $display("FAIL single c%0d req_ready got %b exp %b", c, req_ready, e_ready); end
            vectors++; if (rsp_valid !== e_rsp_valid) begin miscompares++; $display("FAIL single c%0d rsp_valid got %b exp %b", c, rsp_valid, e_rsp_valid); end
            vectors++; if (rsp_p !== e_rsp_p) begin miscompares++; $display("FAIL single c%0d rsp_p got %0d exp %0d", c, rsp_p, e_rsp_p); end
            vectors++; if (busy !== e_busy) begin miscompares++; $display("FAIL single c%0d busy got %b exp %b", c, busy, e_busy); end
            if (c == 3) begin
                vectors++; if (rsp_valid !== 2'b01 || rsp_p !== 22'd100000) begin miscompares++; $display("FAIL single_result got v=%b p=%0d exp v=01 p=100000", rsp_valid, rsp_p); end
            end
            advance();
        end
    endtask

    task automatic test_truncation();
        for (int c = 0; c < 7; c++) begin
            apply(1'b0, (c < 2) ? 2'b01 : 2'b00, {16'd0, 16'd65535},
                  {7'd0, (c == 0) ? 7'd127 : 7'd64}, 2'b11);
            vectors++; if (req_ready !== e_ready) begin miscompares++; $display("FAIL trunc c%0d req_ready got %b exp %b", c, req_ready, e_ready); end
            vectors++; if (rsp_valid !== e_rsp_valid) begin miscompares++; $display("FAIL trunc c%0d rsp_valid got %b exp %b", c, rsp_valid, e_rsp_valid); end
            vectors++; if (rsp_p !== e_rsp_p) begin miscompares++; $display("FAIL trunc c%0d rsp_p got %0d exp %0d", c, rsp_p, e_rsp_p); end
            vectors++; if (busy !== e_busy) begin miscompares++; $display("FAIL trunc c%0d busy got %b exp %b", c, busy, e_busy); end
            if (c == 3) begin
                vectors++; if (rsp_p !== 22'd4128641) begin miscompares++; $display("FAIL trunc_127 got %0d exp 4128641", rsp_p); end
            end
            if (c == 4) begin
                vectors++; if (rsp_p !== 22'd4194240) begin miscompares++; $display("FAIL trunc_64 got %0d exp 4194240", rsp_p); end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] v;
        for (int c = 0; c < 13; c++) begin
            v = (c == 0) ? 2'b10 : ((c >= 3 && c <= 7) ? 2'b11 : 2'b00);
            apply(1'b0, v, {16'd3000, 16'd7}, {7'd50, 7'd9}, (c <= 7) ? 2'b01 : 2'b11);
            vectors++; if (req_ready !== e_ready) begin miscompares++; $display("FAIL bp c%0d req_ready got %b exp %b", c, req_ready, e_ready); end
            vectors++; if (rsp_valid !== e_rsp_valid) begin miscompares++; $display("FAIL bp c%0d rsp_valid got %b exp %b", c, rsp_valid, e_rsp_valid); end
            vectors++; if (rsp_p !== e_rsp_p) begin miscompares++; $display("FAIL bp c%0d rsp_p got %0d exp %0d", c, rsp_p, e_rsp_p); end
            vectors++; if (busy !== e_busy) begin miscompares++; $display("FAIL bp c%0d busy got %b exp %b", c, busy, e_busy); end
            if (c >= 3 && c <= 8) begin
                vectors++; if (rsp_valid !== 2'b10 || rsp_p !== 22'd150000) begin miscompares++; $display("FAIL bp_hold c%0d got v=%b p=%0d exp v=10 p=150000", c, rsp_valid, rsp_p); end
            end
            if (c >= 3 && c <= 7) begin
                vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL bp_stall c%0d req_ready got %b exp 00", c, req_ready); end
            end
            advance();
        end
    endtask

    task automatic test_reset_midflight();
        logic [N-1:0] v;
        for (int c = 0; c < 15; c++) begin
            v = (c <= 2 || c == 10) ? 2'b11 : 2'b00;
            apply(c == 3, v, $urandom, 14'($urandom), 2'b11);
            vectors++; if (req_ready !== e_ready) begin miscompares++; $display("FAIL rstmid c%0d req_ready got %b exp %b", c, req_ready, e_ready); end
            vectors++; if (rsp_valid !== e_rsp_valid) begin miscompares++; $display("FAIL rstmid c%0d rsp_valid got %b exp %b", c, rsp_valid, e_rsp_valid); end
            vectors++; if (rsp_p !== e_rsp_p) begin miscompares++; $display("FAIL rstmid c%0d rsp_p got %0d exp %0d", c, rsp_p, e_rsp_p); end
            vectors++; if (busy !== e_busy) begin miscompares++; $display("FAIL rstmid c%0d busy got %b exp %b", c, busy, e_busy); end
            if (c >= 3 && c <= 9) begin
                vectors++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_flush c%0d got v=%b busy=%b exp v=00 busy=0", c, rsp_valid, busy); end
            end
            if (c == 10) begin
                vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rstmid_grant got %b exp 01", req_ready); end
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic          rst;
        logic [N-1:0]  rdy;
        logic [13:0]   b;
        for (int c = 0; c < 610; c++) begin
            rst = (c < 600) && ($urandom_range(0, 49) == 0);
            rdy = (c < 600) ? {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)} : 2'b11;
            b   = ($urandom_range(0, 7) == 0) ? 14'h3fff : 14'($urandom);
            apply(rst, (c < 600) ? 2'($urandom) : 2'b00,
                  ($urandom_range(0, 7) == 0) ? 32'hffff_ffff : $urandom, b, rdy);
            vectors++; if (req_ready !== e_ready) begin miscompares++; $display("FAIL rand c%0d req_ready got %b exp %b", c, req_ready, e_ready); end
            vectors++; if (rsp_valid !== e_rsp_valid) begin miscompares++; $display("FAIL rand c%0d rsp_valid got %b exp %b", c, rsp_valid, e_rsp_valid); end
            vectors++; if (rsp_p !== e_rsp_p) begin miscompares++; $display("FAIL rand c%0d rsp_p got %0d exp %0d", c, rsp_p, e_rsp_p); end
            vectors++; if (busy !== e_busy) begin miscompares++; $display("FAIL rand c%0d busy got %b exp %b", c, busy, e_busy); end
            advance();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rr          = 0;
        t_eff       = 0;
        reset       = 1'b1;
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        rsp_ready   = '0;
        test_reset();
        test_fairness();
        test_single_op();
        test_truncation();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d vectors", vectors);
        $fatal(1);
    end

endmodule

// File: doc/infer_mul_arbiter.md
INFER_MUL_ARBITER -- requirements
Module: infer_mul_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, number of requesters sharing the multiplier (legal 2..4).
REQ-002 The block SHALL have parameter MUL_LATENCY, default 3, cycles from ce-qualified operand capture to product on multiplier dout.
REQ-003 The block SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid  input  NUM_REQ  per-requester operand-valid.
REQ-006 The block SHALL have port req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
REQ-007 The block SHALL have port req_a  input  NUM_REQ*16  packed unsigned multiplicands; requester i occupies bits [16i+15:16i].
REQ-008 The block SHALL have port req_b  input  NUM_REQ*7  packed unsigned multipliers; requester i occupies bits [7i+6:7i].
REQ-009 The block SHALL have port rsp_valid  output  NUM_REQ  per-requester result-valid, one-hot or zero.
REQ-010 The block SHALL have port rsp_ready  input  NUM_REQ  per-requester result-accept.
REQ-011 The block SHALL have port rsp_p  output  22  shared product bus.
REQ-012 The block SHALL have port busy  output  1  high while any operation is in flight.

Function
REQ-013 Transfer SHALL occur on req_valid[i] & req_ready[i] (request) and rsp_valid[i] & rsp_ready[i] (response) at a rising edge.
REQ-014 Global stall: ce = NOT(out_vld AND NOT rsp_ready[out_tag]); ce SHALL drive the multiplier ce and every tracking stage.
REQ-015 Grant SHALL be round-robin: first valid requester at or after pointer rr_ptr, wrapping from NUM_REQ-1 to 0.
REQ-016 req_ready[g] SHALL be 1 only for granted g and only when ce=1; req_ready is combinational from req_valid, rr_ptr, ce.
REQ-017 On an accepted request, rr_ptr SHALL update to (g+1) mod NUM_REQ; otherwise it holds.
REQ-018 At most one request SHALL be accepted per cycle; none when ce=0.
REQ-019 A MUL_LATENCY-deep valid/tag pipeline SHALL shift on ce=1 only, inserting {accepted, g}; bubbles SHALL NOT be compressed.
REQ-020 out_vld/out_tag SHALL be the last pipeline stage; rsp_valid[i] = out_vld AND (out_tag==i).
REQ-021 rsp_p SHALL equal the low 22 bits of a*b when out_vld=1 and 0 when out_vld=0; products >= 2^22 truncate silently.
REQ-022 With no stall, a result SHALL appear on rsp_valid exactly MUL_LATENCY cycles after acceptance; throughput one op per cycle.
REQ-023 While stalled, rsp_p, rsp_valid, all stages and rr_ptr SHALL hold; results SHALL be delivered in acceptance order.
REQ-024 Simultaneous response accept and new request in one cycle SHALL both complete (ce=1 that cycle).
REQ-025 busy SHALL be OR of all pipeline valid bits.

Reset
REQ-026 While reset=1: all valid bits 0, tags 0, rr_ptr 0; req_ready, rsp_valid, rsp_p, busy SHALL read 0.
REQ-027 Reset mid-operation SHALL discard all in-flight ops; no rsp_valid in the cycle after reset deasserts.
REQ-028 Multiplier data registers need no reset; REQ-021 gating hides their contents.

Structure
REQ-029 Shared package infer_mul_arb_pkg SHALL hold A_W=16, B_W=7, P_W=22, default MUL_LATENCY and the tag-width function.
REQ-030 The multiplier SHALL be one sub-module instance, infer_mul_mul_16ns_7ns_22_4_1, clk/reset/ce driven by this block.
REQ-031 Arbiter, tag pipeline and output gating SHALL be local logic; no other sub-modules.

Verification
REQ-032 Single op: req 0 a=1000 b=100, rsp_ready=1 -> rsp_valid[0] 3 cycles later, rsp_p=100000.
REQ-033 Truncation: a=65535 b=127 -> rsp_p=4128641; a=65535 b=64 -> rsp_p=4194240.
REQ-034 Fairness: both requesters valid for 6 cycles -> grants 0,1,0,1,0,1; results tagged in the same order.
REQ-035 Backpressure: result for req 1 with rsp_ready[1]=0 for 5 cycles -> ce=0, req_ready=0, rsp_p held; delivered on rsp_ready[1]=1.
REQ-036 Reset mid-flight: 3 ops accepted, reset pulsed 1 cycle -> busy=0, no rsp_valid afterwards, next grant to requester 0.
